// File: rtl/ilm_pkg.sv
// Shared widths, leading-one detector and stage payload type for the ilm_ae_pipe datapath.
// Payload fields are sized for the widest legal operand; narrower instances zero-extend.
package ilm_pkg;

  localparam int MAX_W = 32;

  function automatic int LOD_W(input int w);
    return $clog2(w);
  endfunction

  localparam int K_W = LOD_W(MAX_W);

  typedef struct packed {
    logic             valid;
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] y;
    logic [K_W-1:0]   k1;
    logic [K_W-1:0]   k2;
    logic [MAX_W-1:0] xr;
    logic [MAX_W-1:0] yr;
    logic             exact;
  } stage_t;

  // Highest set bit index; a zero input yields 0 and is flagged separately downstream.
  function automatic logic [K_W-1:0] lod(input logic [MAX_W-1:0] v);
    logic [K_W-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) k = i[K_W-1:0];
    end
    return k;
  endfunction

endpackage

// File: rtl/ilm_ae_core.sv
// Combinational one-iteration log-multiplier: 2^(k1+k2) + xr*2^k2 + yr*2^k1.
// With ILM_EXACT_MODE_EN defined, an exact x*y can be selected per operation.
module ilm_ae_core
  import ilm_pkg::*;
(
  input  logic [K_W-1:0]     k1,
  input  logic [K_W-1:0]     k2,
  input  logic [MAX_W-1:0]   xr,
  input  logic [MAX_W-1:0]   yr,
  input  logic               zero,
  output logic [2*MAX_W-1:0] p
`ifdef ILM_EXACT_MODE_EN
  ,
  input  logic               exact,
  input  logic [MAX_W-1:0]   x,
  input  logic [MAX_W-1:0]   y
`endif
);

  localparam int PW = 2 * MAX_W;

  logic [K_W:0]  w_ksum;
  logic [PW-1:0] w_approx;

  assign w_ksum   = {1'b0, k1} + {1'b0, k2};
  assign w_approx = (PW'(1) << w_ksum) + (PW'(xr) << k2) + (PW'(yr) << k1);

  always_comb begin
    p = w_approx;
`ifdef ILM_EXACT_MODE_EN
    if (exact) p = PW'(x) * PW'(y);
`endif
    // The LOD of zero is 0, which would otherwise leave a spurious 2^k term.
    if (zero) p = '0;
  end

endmodule

// File: rtl/ilm_ae_pipe.sv
// Pipelined approximate log multiplier with valid/ready handshake and global stall.
// Optional exact-product port enabled by ILM_EXACT_MODE_EN.
module ilm_ae_pipe
  import ilm_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
`ifdef ILM_EXACT_MODE_EN
  ,
  input  logic           exact
`endif
);

  localparam int PW = 2 * W;
  localparam int DN = STAGES - 1;

  stage_t              r_s0;
  stage_t              r_s1;
  stage_t              w_s0_d;
  stage_t              w_s1_d;
  logic [DN-1:0]       r_dv;
  logic [PW-1:0]       r_dp [DN];
  logic                w_adv;
  logic                w_zero;
  logic [2*MAX_W-1:0]  w_core_p;
  logic [2*$bits(stage_t)+2*MAX_W-1:0] w_unused_bits;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_s0_d       = '0;
    w_s0_d.valid = in_valid;
    w_s0_d.x     = MAX_W'(x);
    w_s0_d.y     = MAX_W'(y);
`ifdef ILM_EXACT_MODE_EN
    w_s0_d.exact = exact;
`endif
    w_s1_d    = r_s0;
    w_s1_d.k1 = lod(r_s0.x);
    w_s1_d.k2 = lod(r_s0.y);
    w_s1_d.xr = r_s0.x ^ (MAX_W'(1) << w_s1_d.k1);
    w_s1_d.yr = r_s0.y ^ (MAX_W'(1) << w_s1_d.k2);
  end

  assign w_zero = (r_s1.x == '0) | (r_s1.y == '0);

  ilm_ae_core u_core (
    .k1    (r_s1.k1),
    .k2    (r_s1.k2),
    .xr    (r_s1.xr),
    .yr    (r_s1.yr),
    .zero  (w_zero),
    .p     (w_core_p)
`ifdef ILM_EXACT_MODE_EN
    ,
    .exact (r_s1.exact),
    .x     (r_s1.x),
    .y     (r_s1.y)
`endif
  );

  // Stage 0 captures operands, stage 1 the LOD/residues, then the product and its delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_dv <= '0;
      for (int i = 0; i < DN; i++) r_dp[i] <= '0;
    end else if (w_adv) begin
      r_s0    <= w_s0_d;
      r_s1    <= w_s1_d;
      r_dv[0] <= r_s1.valid;
      r_dp[0] <= w_core_p[PW-1:0];
      for (int i = 1; i < DN; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_dp[i] <= r_dp[i-1];
      end
    end
  end

  assign out_valid = r_dv[DN-1];
  assign p         = r_dp[DN-1];

  // Padding bits of the shared payload and the product above 2*W are intentionally dropped.
  assign w_unused_bits = {r_s0, r_s1, w_core_p};

endmodule

// File: tb/tb_ilm_ae_pipe.sv
// Bench for ilm_ae_pipe: vector table, stream/stall/reset sequences and random traffic
// on a W=16/STAGES=2 instance plus a concurrent W=8/STAGES=4 instance.
module tb_ilm_ae_pipe;

  localparam int W = 16;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x, y;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;
  logic          exact_i = 1'b0;

  logic          iv8 = 1'b0, or8 = 1'b1, ir8, ov8, ex8 = 1'b0;
  logic [7:0]    x8 = '0, y8 = '0;
  logic [15:0]   p8;
  bit            run8 = 1'b0;

  int n_cmp = 0, n_fail = 0;
  int n_push = 0, n_ret = 0, cyc = 0;
  bit mon_en = 1'b0;
  longint unsigned q[$], q8[$];
  int ret_cyc[$];

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           ex;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ilm_ae_pipe #(.W(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .p(p)
`ifdef ILM_EXACT_MODE_EN
    , .exact(exact_i)
`endif
  );

  ilm_ae_pipe #(.W(8), .STAGES(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .out_valid(ov8), .out_ready(or8), .p(p8)
`ifdef ILM_EXACT_MODE_EN
    , .exact(ex8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the true product minus the residue product xr*yr, or x*y in exact mode.
  function automatic longint unsigned model(longint unsigned a, longint unsigned b, bit ex);
    int ka, kb;
    if (a == 0 || b == 0) return 0;
    if (ex) return a * b;
    ka = 0;
    kb = 0;
    while ((a >> (ka + 1)) != 0) ka++;
    while ((b >> (kb + 1)) != 0) kb++;
    return a * b - (a - (64'd1 << ka)) * (b - (64'd1 << kb));
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(32'd1 << $urandom_range(0, W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic bit pick_ex();
    bit e;
    e = 1'b0;
`ifdef ILM_EXACT_MODE_EN
    e = ($urandom_range(0, 1) == 1);
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (in_valid && in_ready) begin
        q.push_back(model(64'(x), 64'(y), exact_i));
        n_push++;
      end
      if (out_valid && out_ready) begin
        n_ret++;
        ret_cyc.push_back(cyc);
        check("out_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) check("stream_p", 64'(p), q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (run8) begin
      or8 = ($urandom_range(0, 3) != 0);
      iv8 = ($urandom_range(0, 2) != 0);
      x8  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      y8  = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      ex8 = pick_ex();
    end else begin
      iv8 = 1'b0;
      or8 = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (iv8 && ir8) q8.push_back(model(64'(x8), 64'(y8), ex8));
      if (ov8 && or8) begin
        check("w8_out_expected", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) check("w8_p", 64'(p8), q8.pop_front());
      end
    end
  end

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic e,
                         output logic [2*W-1:0] res, output int lat);
    x = a;
    y = b;
    exact_i = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = p;
    @(posedge clk);
    #1;
    check("valid_pulse", 64'(out_valid), 64'd0);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while (q.size() != 0 && g < 30) begin
      @(posedge clk);
      #1;
      g++;
    end
    check({name, "_drained"}, 64'(q.size()), 64'd0);
    check({name, "_count"}, 64'(n_ret), 64'(n_push));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] got, p0;
    int lat, n, seen;

    tbl.push_back('{16'd3,     16'd3,     1'b0, 32'd8});
    tbl.push_back('{16'd4,     16'd5,     1'b0, 32'd20});
    tbl.push_back('{16'd0,     16'd1234,  1'b0, 32'd0});
    tbl.push_back('{16'd1234,  16'd0,     1'b0, 32'd0});
    tbl.push_back('{16'hFFFF,  16'hFFFF,  1'b0, 32'hBFFF0000});
    tbl.push_back('{16'd1,     16'hFFFF,  1'b0, 32'h0000FFFF});
    tbl.push_back('{16'h8000,  16'h8000,  1'b0, 32'h40000000});
    tbl.push_back('{16'd6,     16'd7,     1'b0, 32'd36});
    tbl.push_back('{16'd12,    16'd10,    1'b0, 32'd112});
    tbl.push_back('{16'd255,   16'd2,     1'b0, 32'd510});
`ifdef ILM_EXACT_MODE_EN
    tbl.push_back('{16'd3,     16'd3,     1'b1, 32'd9});
    tbl.push_back('{16'hFFFF,  16'hFFFF,  1'b1, 32'hFFFE0001});
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i]) begin
      run_one(tbl[i].x, tbl[i].y, tbl[i].ex, got, lat);
      check($sformatf("vec%0d_p", i), 64'(got), 64'(tbl[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
    end
    exact_i = 1'b0;

    // Back-to-back stream, results must come out on consecutive cycles.
    mon_en = 1'b1;
    ret_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      x = pick();
      y = pick();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    drain("stream");
    check("stream_results", 64'(ret_cyc.size()), 64'd8);
    if (ret_cyc.size() == 8) check("stream_consecutive", 64'(ret_cyc[7] - ret_cyc[0]), 64'd7);

    // Fill under backpressure, hold, then release with a pending input.
    out_ready = 1'b0;
    n = 0;
    while (in_ready && n < 8) begin
      x = pick();
      y = pick();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    x = 16'd77;
    y = 16'd91;
    check("stall_fill", 64'(n), 64'(S + 1));
    p0 = p;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_p", 64'(p), 64'(p0));
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drain("stall");

    // Reset with two operations in flight.
    x = 16'd9;
    y = 16'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    x = 16'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_p", 64'(p), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    n_push = n_ret;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", 64'(seen), 64'd0);

    // Random traffic with random backpressure on both instances.
    run8 = 1'b1;
    repeat (400) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      x = pick();
      y = pick();
      exact_i = pick_ex();
      @(posedge clk);
      #1;
    end
    run8 = 1'b0;
    exact_i = 1'b0;
    drain("random");
    repeat (10) @(posedge clk);
    #1;
    check("w8_drained", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
